// File: rtl/alu_operand_loader.sv
// Operand entry stage: debounces one push button and captures A, B and opcode on
// three successive presses, then offers them downstream with a valid/ready handshake.
// Optional build macro ALU_LOADER_PRESS_CNT_EN adds an 8-bit completed-handshake counter (txn_cnt).
module alu_operand_loader #(
    parameter int DATA_W          = 4,
    parameter int OP_W            = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    input  logic              clr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic [1:0]        state_out
`ifdef ALU_LOADER_PRESS_CNT_EN
    ,
    output logic [7:0]        txn_cnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        ISSUE   = 2'b11
    } state_t;

    logic             s1_reg;
    logic             s2_reg;
    logic             deb_reg;
    logic             deb_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press;
    state_t           state_reg;

    // Two-flop synchroniser, then a level is accepted only after it has been
    // stable for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            deb_reg   <= 1'b0;
            deb_d_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            s1_reg    <= btn;
            s2_reg    <= s1_reg;
            deb_d_reg <= deb_reg;
            if (s2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                deb_reg <= s2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Rising edge of the debounced level only; releases make no pulse.
    assign press = deb_reg & ~deb_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD_A;
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
        end else if (clr) begin
            state_reg <= LOAD_A;
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
        end else begin
            case (state_reg)
                LOAD_A: if (press) begin
                    a_out     <= sw_data;
                    state_reg <= LOAD_B;
                end
                LOAD_B: if (press) begin
                    b_out     <= sw_data;
                    state_reg <= LOAD_OP;
                end
                LOAD_OP: if (press) begin
                    op_out    <= sw_op;
                    valid_out <= 1'b1;
                    state_reg <= ISSUE;
                end
                ISSUE: if (valid_out && ready_in) begin
                    valid_out <= 1'b0;
                    state_reg <= LOAD_A;
                end
                default: state_reg <= LOAD_A;
            endcase
        end
    end

    assign state_out = state_reg;

`ifdef ALU_LOADER_PRESS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= 8'd0;
        end else if (clr) begin
            txn_cnt <= 8'd0;
        end else if (state_reg == ISSUE && valid_out && ready_in) begin
            txn_cnt <= txn_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4; expected values are
// hand-computed constants. Inputs change and outputs are sampled on the falling edge.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] sw_data = 4'h0;
    logic [2:0] sw_op = 3'b000;
    logic       ready_in = 1'b0;
    logic       valid_out;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [2:0] op_out;
    logic [1:0] state_out;
`ifdef ALU_LOADER_PRESS_CNT_EN
    logic [7:0] txn_cnt;
`endif

    int tests = 0;
    int fails = 0;

    alu_operand_loader #(
        .DATA_W(4),
        .OP_W(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .clr(clr),
        .sw_data(sw_data),
        .sw_op(sw_op),
        .ready_in(ready_in),
        .valid_out(valid_out),
        .a_out(a_out),
        .b_out(b_out),
        .op_out(op_out),
        .state_out(state_out)
`ifdef ALU_LOADER_PRESS_CNT_EN
        ,
        .txn_cnt(txn_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Hold the button long enough to register, then release long enough to debounce.
    task automatic do_press();
        btn = 1'b1;
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset
        ticks(3);
        chk("rst_valid", {7'd0, valid_out}, 8'd0);
        chk("rst_a", {4'd0, a_out}, 8'd0);
        chk("rst_b", {4'd0, b_out}, 8'd0);
        chk("rst_op", {5'd0, op_out}, 8'd0);
        chk("rst_state", {6'd0, state_out}, 8'd0);
        rst_n = 1'b1;
        ticks(2);

        // Capture A, checking the seven-edge press latency
        sw_data = 4'h5;
        btn = 1'b1;
        ticks(6);
        chk("lat_a_edge6", {4'd0, a_out}, 8'h0);
        ticks(1);
        chk("lat_a_edge7", {4'd0, a_out}, 8'h5);
        chk("state_load_b", {6'd0, state_out}, 8'd1);
        ticks(3);
        btn = 1'b0;
        ticks(8);

        sw_data = 4'h3;
        do_press();
        chk("b_capture", {4'd0, b_out}, 8'h3);
        chk("state_load_op", {6'd0, state_out}, 8'd2);
        chk("valid_before_op", {7'd0, valid_out}, 8'd0);

        sw_op = 3'b001;
        sw_data = 4'hA;
        do_press();
        chk("op_capture", {5'd0, op_out}, 8'h1);
        chk("valid_issue", {7'd0, valid_out}, 8'd1);
        chk("state_issue", {6'd0, state_out}, 8'd3);

        // ISSUE holds with ready low; an extra press is discarded
        ticks(10);
        sw_data = 4'hF;
        sw_op = 3'b111;
        do_press();
        chk("hold_a", {4'd0, a_out}, 8'h5);
        chk("hold_b", {4'd0, b_out}, 8'h3);
        chk("hold_op", {5'd0, op_out}, 8'h1);
        chk("hold_valid", {7'd0, valid_out}, 8'd1);
        chk("hold_state", {6'd0, state_out}, 8'd3);

        // Handshake
        ready_in = 1'b1;
        ticks(1);
        ready_in = 1'b0;
        chk("hs_valid", {7'd0, valid_out}, 8'd0);
        chk("hs_state", {6'd0, state_out}, 8'd0);
        chk("hs_keep_a", {4'd0, a_out}, 8'h5);
        chk("hs_keep_b", {4'd0, b_out}, 8'h3);
        chk("hs_keep_op", {5'd0, op_out}, 8'h1);
        ticks(4);
        chk("ready_ignored_valid", {7'd0, valid_out}, 8'd0);

        // Three-cycle glitch produces no capture
        sw_data = 4'h9;
        btn = 1'b1;
        ticks(3);
        btn = 1'b0;
        ticks(10);
        chk("glitch_state", {6'd0, state_out}, 8'd0);
        chk("glitch_a", {4'd0, a_out}, 8'h5);

        // clr coincident with the press pulse in LOAD_OP
        sw_data = 4'h9;
        do_press();
        sw_data = 4'h6;
        do_press();
        chk("pre_clr_state", {6'd0, state_out}, 8'd2);
        chk("pre_clr_a", {4'd0, a_out}, 8'h9);
        sw_op = 3'b101;
        btn = 1'b1;
        ticks(6);
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        chk("clr_state", {6'd0, state_out}, 8'd0);
        chk("clr_a", {4'd0, a_out}, 8'h0);
        chk("clr_b", {4'd0, b_out}, 8'h0);
        chk("clr_op", {5'd0, op_out}, 8'h0);
        chk("clr_valid", {7'd0, valid_out}, 8'd0);
        ticks(3);
        btn = 1'b0;
        ticks(8);
        chk("clr_press_lost", {6'd0, state_out}, 8'd0);

        // Reset mid-sequence, button held through reset release
        sw_data = 4'h7;
        do_press();
        chk("mid_a", {4'd0, a_out}, 8'h7);
        btn = 1'b1;
        ticks(2);
        rst_n = 1'b0;
        ticks(1);
        chk("mid_rst_a", {4'd0, a_out}, 8'h0);
        chk("mid_rst_state", {6'd0, state_out}, 8'd0);
        sw_data = 4'hC;
        ticks(2);
        rst_n = 1'b1;
        ticks(10);
        chk("held_rst_a", {4'd0, a_out}, 8'hC);
        chk("held_rst_state", {6'd0, state_out}, 8'd1);
        btn = 1'b0;
        ticks(8);
        chk("held_single_press", {6'd0, state_out}, 8'd1);

`ifdef ALU_LOADER_PRESS_CNT_EN
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        chk("cnt_clr", txn_cnt, 8'd0);
        for (int i = 0; i < 256; i++) begin
            sw_data = 4'(i);
            do_press();
            do_press();
            do_press();
            ready_in = 1'b1;
            ticks(1);
            ready_in = 1'b0;
            if (i == 0) chk("cnt_one", txn_cnt, 8'd1);
            if (i == 254) chk("cnt_255", txn_cnt, 8'd255);
        end
        chk("cnt_wrap", txn_cnt, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
